spi_reg_writer: RTL and testbench

SPI controller that writes one 8-bit value to a 7-bit register address over a 16-bit mode-0 frame. It is the initiator end of the register-write link used to program the PWM peripheral's output-enable, PWM-enable and duty-cycle registers. It is used on-chip for self-test, and by the verification bench as the bus-functional driver. It drives SCLK, COPI and nCS from the system clock and exposes a single-transaction start/busy/done handshake to local logic.

---
 rtl/spi_reg_writer.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_reg_writer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_writer.sv
// -----------------------------------------------------------------------------
// spi_reg_writer
//
// SPI mode-0 initiator that writes one 8-bit value to a 7-bit register address
// using a single 16-bit frame {1'b1, wr_addr, wr_data}, MSB first. It is the
// initiator end of the register-write link that programs the PWM peripheral.
//
// Ports:
//   clk      in   system clock, all state changes on its rising edge
//   rst      in   asynchronous active-high reset
//   start    in   write request, sampled only while busy is low
//   wr_addr  in   7-bit target register address, latched on accepted start
//   wr_data  in   8-bit value to write, latched on accepted start
//   busy     out  high from the cycle after an accepted start through GAP
//   done     out  one-cycle pulse in the cycle ncs rises at frame end
//   sclk     out  SPI clock, idle low
//   copi     out  serial data, changes only while sclk is low
//   ncs      out  chip select, active low
//
// Parameter:
//   CLK_DIV  SCLK half-period in clk cycles, legal range 2..255
// -----------------------------------------------------------------------------
module spi_reg_writer #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       busy,
   output logic       done,
   output logic       sclk,
   output logic       copi,
   output logic       ncs
);

   // Half-period counter width and its terminal value.
   localparam int            CW       = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // Number of the last bit position counted by the bit counter.
   localparam logic [4:0] BIT_LAST = 5'd15;

   // State encoding.
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SETUP    = 3'd1;
   localparam logic [2:0] ST_SHIFT_HI = 3'd2;
   localparam logic [2:0] ST_SHIFT_LO = 3'd3;
   localparam logic [2:0] ST_HOLD     = 3'd4;
   localparam logic [2:0] ST_GAP      = 3'd5;

   // Assemble the 16-bit write frame; bit 15 is the write flag.
   function automatic logic [15:0] build_frame(input logic [6:0] addr,
                                               input logic [7:0] data);
      build_frame = {1'b1, addr, data};
   endfunction

   // Registered state.
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [4:0]    bit_cnt;
   logic [15:0]   shift_reg;
   logic          busy_q;
   logic          done_q;
   logic          sclk_q;
   logic          copi_q;
   logic          ncs_q;

   // Next-state values.
   logic [2:0]    state_nxt;
   logic [CW-1:0] cnt_nxt;
   logic [4:0]    bit_cnt_nxt;
   logic [15:0]   shift_nxt;
   logic          busy_nxt;
   logic          done_nxt;
   logic          sclk_nxt;
   logic          copi_nxt;
   logic          ncs_nxt;

   logic          phase_end;
   logic [15:0]   frame;

   assign phase_end = (cnt == CNT_LAST);
   assign frame     = build_frame(wr_addr, wr_data);

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so every port comes straight from a flop.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift_reg;
      busy_nxt    = busy_q;
      done_nxt    = 1'b0;
      sclk_nxt    = sclk_q;
      copi_nxt    = copi_q;
      ncs_nxt     = ncs_q;

      case (state)
         ST_IDLE: begin
            if (start) begin
               // Frame is captured here; later input changes do not affect it.
               state_nxt   = ST_SETUP;
               cnt_nxt     = CNT_ZERO;
               bit_cnt_nxt = 5'd0;
               shift_nxt   = frame;
               busy_nxt    = 1'b1;
               ncs_nxt     = 1'b0;
               sclk_nxt    = 1'b0;
               copi_nxt    = frame[15];
            end else begin
               cnt_nxt  = CNT_ZERO;
               busy_nxt = 1'b0;
               ncs_nxt  = 1'b1;
               sclk_nxt = 1'b0;
               copi_nxt = 1'b0;
            end
         end

         ST_SETUP: begin
            if (phase_end) begin
               state_nxt = ST_SHIFT_HI;
               cnt_nxt   = CNT_ZERO;
               sclk_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         ST_SHIFT_HI: begin
            if (phase_end) begin
               cnt_nxt  = CNT_ZERO;
               sclk_nxt = 1'b0;
               if (bit_cnt == BIT_LAST) begin
                  // Last rising edge done; copi keeps bit 0 through HOLD.
                  state_nxt   = ST_HOLD;
                  bit_cnt_nxt = bit_cnt + 5'd1;
               end else begin
                  // Rotate rather than shift so no register bit is left
                  // dangling; the wrapped bit is never transmitted.
                  state_nxt   = ST_SHIFT_LO;
                  bit_cnt_nxt = bit_cnt + 5'd1;
                  shift_nxt   = {shift_reg[14:0], shift_reg[15]};
                  copi_nxt    = shift_reg[14];
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         ST_SHIFT_LO: begin
            if (phase_end) begin
               state_nxt = ST_SHIFT_HI;
               cnt_nxt   = CNT_ZERO;
               sclk_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         ST_HOLD: begin
            if (phase_end) begin
               // done coincides with ncs rising; busy stays high through GAP.
               state_nxt = ST_GAP;
               cnt_nxt   = CNT_ZERO;
               ncs_nxt   = 1'b1;
               done_nxt  = 1'b1;
               copi_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         ST_GAP: begin
            if (phase_end) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = CNT_ZERO;
               busy_nxt  = 1'b0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end

         default: begin
            // Unreachable encodings recover to a clean idle.
            state_nxt   = ST_IDLE;
            cnt_nxt     = CNT_ZERO;
            bit_cnt_nxt = 5'd0;
            shift_nxt   = 16'h0000;
            busy_nxt    = 1'b0;
            sclk_nxt    = 1'b0;
            copi_nxt    = 1'b0;
            ncs_nxt     = 1'b1;
         end
      endcase
   end

   // State and output registers with asynchronous reset to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= CNT_ZERO;
         bit_cnt   <= 5'd0;
         shift_reg <= 16'h0000;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b0;
         copi_q    <= 1'b0;
         ncs_q     <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift_reg <= shift_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
         sclk_q    <= sclk_nxt;
         copi_q    <= copi_nxt;
         ncs_q     <= ncs_nxt;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sclk = sclk_q;
   assign copi = copi_q;
   assign ncs  = ncs_q;

endmodule

// File: tb/tb_spi_reg_writer.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_writer
//
// Self-checking bench for spi_reg_writer. A mode-0 receiver model watches the
// CLK_DIV=4 instance and compares each received frame against a scoreboard
// queue filled when stimulus is driven. A second instance with CLK_DIV=2
// covers the minimum divider.
// -----------------------------------------------------------------------------
module tb_spi_reg_writer;

   logic       clk;
   logic       rst;

   logic       start;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy, done, sclk, copi, ncs;

   logic       start2;
   logic [6:0] wr_addr2;
   logic [7:0] wr_data2;
   logic       busy2, done2, sclk2, copi2, ncs2;

   int checks = 0;
   int errors = 0;

   logic [15:0] sb[$];

   spi_reg_writer #(.CLK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .sclk(sclk), .copi(copi), .ncs(ncs)
   );

   spi_reg_writer #(.CLK_DIV(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .wr_addr(wr_addr2), .wr_data(wr_data2),
      .busy(busy2), .done(done2), .sclk(sclk2), .copi(copi2), .ncs(ncs2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Receiver model for the CLK_DIV=4 instance.
   logic [15:0] m_rx;
   logic [15:0] m_last_rx = 16'h0000;
   int          m_low = 0, m_rises = 0, m_hi = 0, m_last_gap = 0;
   int          m_done_cnt = 0, m_frames = 0;
   logic        m_prev_sclk = 1'b0, m_prev_ncs = 1'b1;

   always @(negedge clk) begin
      if (rst) begin
         m_rx        = 16'h0000;
         m_low       = 0;
         m_rises     = 0;
         m_hi        = 0;
         m_prev_sclk = 1'b0;
         m_prev_ncs  = 1'b1;
      end else begin
         if (done) m_done_cnt++;
         if (!ncs) begin
            if (m_prev_ncs) m_last_gap = m_hi;
            m_low++;
            if (sclk && !m_prev_sclk) begin
               m_rx = {m_rx[14:0], copi};
               m_rises++;
            end
         end else begin
            m_hi++;
            if (!m_prev_ncs) begin
               check("done_at_ncs_rise", {31'd0, done}, 32'd1);
               check("ncs_low_cycles", m_low, 32'd132);
               check("sclk_rises", m_rises, 32'd16);
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL frame: got 0x%0h with no frame expected", m_rx);
               end else begin
                  check("frame", {16'd0, m_rx}, {16'd0, sb.pop_front()});
               end
               m_last_rx = m_rx;
               m_frames++;
               m_low     = 0;
               m_rises   = 0;
               m_hi      = 1;
            end
         end
         m_prev_sclk = sclk;
         m_prev_ncs  = ncs;
      end
   end

   // Single write on the CLK_DIV=4 instance; returns busy-high cycle count and
   // the distance from the done pulse to busy falling.
   task automatic do_write(input logic [6:0] a, input logic [7:0] d,
                           output int n, output int after_done);
      int dn;
      @(negedge clk);
      wr_addr = a;
      wr_data = d;
      start   = 1'b1;
      sb.push_back({1'b1, a, d});
      @(negedge clk);
      start   = 1'b0;
      wr_addr = ~a;
      wr_data = ~d;
      check("first_cycle_ncs", {31'd0, ncs}, 32'd0);
      check("first_cycle_busy", {31'd0, busy}, 32'd1);
      check("first_cycle_copi", {31'd0, copi}, 32'd1);
      n  = 0;
      dn = -100;
      while (busy && n < 1000) begin
         if (done) dn = n;
         n++;
         @(negedge clk);
      end
      after_done = n - dn;
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      logic [6:0]  addr;
      logic [7:0]  data;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int n, ad, d0, w;
      logic ok;
      logic [15:0] rx;
      logic ps;
      int low;

      vecs[0] = '{addr: 7'h00, data: 8'hFF, exp: 16'h80FF};
      vecs[1] = '{addr: 7'h7F, data: 8'h00, exp: 16'hFF00};
      vecs[2] = '{addr: 7'h55, data: 8'hA5, exp: 16'hD5A5};
      vecs[3] = '{addr: 7'h01, data: 8'h3C, exp: 16'h813C};

      rst = 1'b1;
      start = 1'b0; wr_addr = 7'h00; wr_data = 8'h00;
      start2 = 1'b0; wr_addr2 = 7'h00; wr_data2 = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_sclk", {31'd0, sclk}, 32'd0);
      check("reset_copi", {31'd0, copi}, 32'd0);
      check("reset_ncs", {31'd0, ncs}, 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Table-driven single writes.
      for (int i = 0; i < 4; i++) begin
         d0 = m_done_cnt;
         do_write(vecs[i].addr, vecs[i].data, n, ad);
         check("busy_cycles", n, 32'd136);
         check("busy_after_done", ad, 32'd4);
         check("rx_table", {16'd0, m_last_rx}, {16'd0, vecs[i].exp});
         check("done_once", m_done_cnt, d0 + 1);
      end

      // Busy lockout: a second start mid-frame is dropped.
      d0 = m_done_cnt;
      @(negedge clk);
      wr_addr = 7'h02; wr_data = 8'hAA; start = 1'b1;
      sb.push_back(16'h82AA);
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      wr_addr = 7'h03; wr_data = 8'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (busy && w < 1000) begin w++; @(negedge clk); end
      repeat (20) @(negedge clk);
      check("lockout_rx", {16'd0, m_last_rx}, 32'h82AA);
      check("lockout_done", m_done_cnt, d0 + 1);
      check("lockout_sb_empty", sb.size(), 32'd0);

      // Back-to-back frames with start held high.
      d0 = m_done_cnt;
      @(negedge clk);
      wr_addr = 7'h04; wr_data = 8'h80; start = 1'b1;
      sb.push_back(16'h8480);
      sb.push_back(16'h8480);
      w = 0;
      while (m_done_cnt < d0 + 1 && w < 1000) begin w++; @(negedge clk); end
      while (busy && w < 1000) begin w++; @(negedge clk); end
      @(negedge clk);
      start = 1'b0;
      while (busy && w < 1000) begin w++; @(negedge clk); end
      repeat (2) @(negedge clk);
      check("b2b_timeout", {31'd0, (w < 1000)}, 32'd1);
      check("b2b_done", m_done_cnt, d0 + 2);
      check("b2b_rx", {16'd0, m_last_rx}, 32'h8480);
      check("b2b_gap", m_last_gap, 32'd5);
      check("b2b_sb_empty", sb.size(), 32'd0);

      // Reset mid-frame after the 6th sclk rising edge.
      d0 = m_done_cnt;
      @(negedge clk);
      wr_addr = 7'h12; wr_data = 8'h34; start = 1'b1;
      sb.push_back(16'h9234);
      @(negedge clk);
      start = 1'b0;
      w = 0;
      while (m_rises < 6 && w < 1000) begin w++; @(negedge clk); end
      check("rst_wait_rises", m_rises, 32'd6);
      rst = 1'b1;
      #1;
      check("rst_async_ncs", {31'd0, ncs}, 32'd1);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      check("rst_async_sclk", {31'd0, sclk}, 32'd0);
      check("rst_async_copi", {31'd0, copi}, 32'd0);
      check("rst_async_done", {31'd0, done}, 32'd0);
      void'(sb.pop_back());
      ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!ncs || busy || sclk || copi || done) ok = 1'b0;
      end
      check("rst_hold_stable", {31'd0, ok}, 32'd1);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_no_done", m_done_cnt, d0);
      do_write(7'h01, 8'h3C, n, ad);
      check("post_rst_rx", {16'd0, m_last_rx}, 32'h813C);
      check("post_rst_busy", n, 32'd136);

      // Minimum divider on the second instance.
      @(negedge clk);
      wr_addr2 = 7'h7F; wr_data2 = 8'h00; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0; low = 0; rx = 16'h0000; ps = 1'b0;
      while (busy2 && n < 500) begin
         if (!ncs2) begin
            low++;
            if (sclk2 && !ps) rx = {rx[14:0], copi2};
         end
         ps = sclk2;
         n++;
         @(negedge clk);
      end
      check("div2_rx", {16'd0, rx}, 32'hFF00);
      check("div2_ncs_low", low, 32'd66);
      check("div2_busy", n, 32'd68);

      check("final_sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
